// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Drives a 4-digit, common-anode, multiplexed seven-segment display from four
// BCD digits. Digits are captured on a load strobe into a pending buffer and
// moved onto the display only at a scan-frame boundary, so one frame never
// shows a mix of old and new digits. Leading zeros can be blanked, and any
// non-BCD code is shown as a dash.
//
// Parameters:
//   DIV       clock cycles each digit stays lit (must be >= 2)
//   BLANK_LZ  1 = blank leading zeros, 0 = always show all four digits
//
// Ports:
//   clock       system clock, all state changes on the rising edge
//   resetn      synchronous active-low reset
//   thousands   BCD digit 3 (leftmost)
//   hundreds    BCD digit 2
//   tens        BCD digit 1
//   ones        BCD digit 0 (rightmost)
//   load        1-cycle strobe that captures the four digits
//   enable      scan enable; 0 blanks the display and freezes the scan
//   seg         segments {g,f,e,d,c,b,a}, active low
//   an          digit anodes, active low; an[0] = ones, an[3] = thousands
//   frame_done  1-cycle pulse marking the start of a new frame
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int unsigned DIV      = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       load,
    input  logic       enable,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int unsigned     CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Digit word layout: element [0] is ones, element [3] is thousands,
    // matching the anode numbering.
    typedef logic [3:0][3:0] digits_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;         // cycles spent on the current digit
    logic [1:0]       idx;         // digit currently being scanned
    digits_t          disp;        // digits the display is showing this frame
    digits_t          pend;        // last digits loaded since the frame began
    logic             pend_valid;  // pend holds digits not yet displayed

    digits_t          in_digits;
    logic             tick;        // current digit's time slot ends this edge
    logic             boundary;    // last slot of the frame ends this edge

    logic [3:0]       lit;         // per-digit "not blanked" flags
    logic [6:0]       seg_next;
    logic [3:0]       an_next;

    assign in_digits = {thousands, hundreds, tens, ones};

    // The scan only advances while enabled, so a paused display resumes
    // exactly where it stopped instead of restarting the frame.
    assign tick     = enable && (cnt == CNT_MAX);
    assign boundary = tick && (idx == 2'd3);

    // -------------------------------------------------------------------------
    // Segment decode, active low {g,f,e,d,c,b,a}. Codes 10..15 show a dash.
    // -------------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = 7'b0111111;
        endcase
        return pattern;
    endfunction

    // -------------------------------------------------------------------------
    // Prescaler and digit index
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values, regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + 2'd1;  // wraps 3 -> 0 at the frame boundary
        end else if (enable) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Digit capture: pending buffer plus frame-synchronous display update
    // -------------------------------------------------------------------------
    // NOTE: disp and pend are reset explicitly; the display must show a known
    // "0" straight after reset, and pend must never leak stale digits.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (boundary) begin
            // A load on the boundary edge itself goes straight to the new
            // frame; it is newer than anything waiting in pend.
            if (load) begin
                disp <= in_digits;
            end else if (pend_valid) begin
                disp <= pend;
            end
            pend_valid <= 1'b0;
        end else if (load) begin
            pend       <= in_digits;   // last load before the boundary wins
            pend_valid <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero blanking. A digit is lit when it, or any digit to its
    // left, is nonzero; non-BCD codes count as nonzero. Ones is always lit.
    // -------------------------------------------------------------------------
    // NOTE: each always_comb assigns defaults before any condition, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        lit = 4'b1111;
        if (BLANK_LZ) begin
            lit[3] = (disp[3] != 4'd0);
            lit[2] = lit[3] || (disp[2] != 4'd0);
            lit[1] = lit[2] || (disp[1] != 4'd0);
            lit[0] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output selection from the current index; registered below, so the pins
    // lag idx by one cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        seg_next = SEG_OFF;
        an_next  = AN_OFF;
        if (enable && lit[idx]) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = decode(disp[idx]);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            an         <= an_next;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Two instances share one stimulus: dut_a blanks leading zeros, dut_b shows
// all digits. A reference model tracks the scan as a single position within
// the frame, the displayed digits as an array and the loads as a queue, and
// predicts seg/an/frame_done for every edge. A compare process checks both
// instances on every falling edge; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };
    localparam logic [3:0] AN_PAT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       load = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] thousands = 4'd0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;

    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       fd_a, fd_b;

    always #5 clock = ~clock;

    seg7_scan_driver #(.DIV(DIV), .BLANK_LZ(1'b1)) dut_a (
        .clock(clock), .resetn(resetn),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
        .load(load), .enable(enable),
        .seg(seg_a), .an(an_a), .frame_done(fd_a)
    );

    seg7_scan_driver #(.DIV(DIV), .BLANK_LZ(1'b0)) dut_b (
        .clock(clock), .resetn(resetn),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones),
        .load(load), .enable(enable),
        .seg(seg_b), .an(an_b), .frame_done(fd_b)
    );

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    int          m_pos = 0;          // position within frame, 0..FRAME-1
    int          m_digits [4];       // [0]=ones .. [3]=thousands on display
    logic [15:0] m_pend [$];         // loads waiting for the next frame
    bit          m_valid = 1'b0;
    logic [6:0]  e_seg_a = 7'h7F, e_seg_b = 7'h7F;
    logic [3:0]  e_an_a = 4'hF, e_an_b = 4'hF;
    logic        e_fd = 1'b0, e_fd_b = 1'b0;

    function automatic bit slot_lit(input int k, input bit blz);
        if (k == 0 || !blz) return 1'b1;
        for (int j = k; j < 4; j++) begin
            if (m_digits[j] != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic show(input logic [15:0] w);
        m_digits[3] = int'(w[15:12]);
        m_digits[2] = int'(w[11:8]);
        m_digits[1] = int'(w[7:4]);
        m_digits[0] = int'(w[3:0]);
    endtask

    task automatic model_step();
        int slot;
        bit boundary;
        if (!resetn) begin
            m_pos = 0;
            show(16'h0000);
            m_pend.delete();
            e_seg_a = 7'h7F; e_an_a = 4'hF;
            e_seg_b = 7'h7F; e_an_b = 4'hF;
            e_fd = 1'b0; e_fd_b = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            slot = m_pos / DIV;
            e_seg_a = 7'h7F; e_an_a = 4'hF;
            e_seg_b = 7'h7F; e_an_b = 4'hF;
            if (enable && slot_lit(slot, 1'b1)) begin
                e_an_a  = AN_PAT[slot];
                e_seg_a = GLYPH[m_digits[slot]];
            end
            if (enable && slot_lit(slot, 1'b0)) begin
                e_an_b  = AN_PAT[slot];
                e_seg_b = GLYPH[m_digits[slot]];
            end
            boundary = enable && (m_pos == FRAME - 1);
            e_fd   = boundary;
            e_fd_b = boundary;
            if (boundary) begin
                if (load) show({thousands, hundreds, tens, ones});
                else if (m_pend.size() > 0) show(m_pend[$]);
                m_pend.delete();
            end else if (load) begin
                m_pend.push_back({thousands, hundreds, tens, ones});
            end
            if (enable) m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (m_valid) begin
            check("seg_a", seg_a, e_seg_a);
            check("an_a", an_a, e_an_a);
            check("frame_done_a", fd_a, e_fd);
            check("seg_b", seg_b, e_seg_b);
            check("an_b", an_b, e_an_b);
            check("frame_done_b", fd_b, e_fd_b);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // -------------------------------------------------------------------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load(input logic [3:0] d3, input logic [3:0] d2,
                           input logic [3:0] d1, input logic [3:0] d0);
        thousands = d3; hundreds = d2; tens = d1; ones = d0;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (m_pos == p) return;
            @(negedge clock);
        end
        check("wait_pos_timeout", 32'd0, 32'd1);
    endtask

    // Returns just after the boundary edge (frame_done visible).
    task automatic wait_frame();
        wait_pos(FRAME - 1);
        @(negedge clock);
    endtask

    function automatic logic [3:0] rand_digit();
        return ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    endfunction

    // -------------------------------------------------------------------------
    // Directed scenarios followed by random traffic
    // -------------------------------------------------------------------------
    initial begin
        int n;

        // Reset held 2 cycles with load asserted.
        resetn = 1'b0; enable = 1'b1;
        thousands = 4'd8; hundreds = 4'd8; tens = 4'd8; ones = 4'd8; load = 1'b1;
        cycles(2);
        check("rst_seg", seg_a, 7'h7F);
        check("rst_an", an_a, 4'hF);
        check("rst_fd", fd_a, 1'b0);
        resetn = 1'b1; load = 1'b0;
        cycles(1);
        check("post_rst_seg", seg_a, 7'b1000000);
        check("post_rst_an", an_a, 4'b1110);
        check("post_rst_an_b", an_b, 4'b1110);

        // Load 1,2,3,4 mid-frame; shown from the next frame.
        cycles(2);
        do_load(4'd1, 4'd2, 4'd3, 4'd4);
        wait_frame();
        check("first_fd", fd_a, 1'b1);
        cycles(1);
        check("slot0_an", an_a, 4'b1110);
        check("slot0_seg", seg_a, 7'b0011001);
        cycles(DIV);
        check("slot1_an", an_a, 4'b1101);
        check("slot1_seg", seg_a, 7'b0110000);
        cycles(DIV);
        check("slot2_an", an_a, 4'b1011);
        check("slot2_seg", seg_a, 7'b0100100);
        cycles(DIV);
        check("slot3_an", an_a, 4'b0111);
        check("slot3_seg", seg_a, 7'b1111001);
        for (int i = 0; i < 2 * FRAME && !fd_a; i++) @(negedge clock);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!fd_a && n < 2 * FRAME);
        check("frame_period", n, FRAME);

        // Leading-zero blanking.
        do_load(4'd0, 4'd0, 4'd0, 4'd7);
        wait_frame();
        cycles(1);
        check("blank_ones_seg", seg_a, 7'b1111000);
        check("blank_ones_an", an_a, 4'b1110);
        cycles(DIV);
        check("blank_tens_an", an_a, 4'hF);
        check("blank_tens_seg", seg_a, 7'h7F);
        check("noblank_tens_an", an_b, 4'b1101);
        check("noblank_tens_seg", seg_b, 7'b1000000);
        do_load(4'd0, 4'd0, 4'd0, 4'd0);
        wait_frame();
        cycles(FRAME);

        // Two loads in one frame: last wins.
        wait_frame();
        do_load(4'd1, 4'd1, 4'd1, 4'd1);
        do_load(4'd5, 4'd5, 4'd5, 4'd5);
        wait_frame();
        cycles(1);
        check("last_wins_seg", seg_a, 7'b0010010);

        // Load on the boundary edge goes straight to the new frame.
        wait_pos(FRAME - 1);
        do_load(4'd9, 4'd9, 4'd9, 4'd9);
        check("bnd_load_fd", fd_a, 1'b1);
        cycles(1);
        check("bnd_load_seg", seg_a, 7'b0010000);
        check("bnd_load_an", an_a, 4'b1110);

        // Non-BCD digit shows a dash.
        do_load(4'd0, 4'd0, 4'hA, 4'd3);
        wait_frame();
        cycles(1);
        check("inv_ones_seg", seg_a, 7'b0110000);
        cycles(DIV);
        check("inv_tens_seg", seg_a, 7'b0111111);
        check("inv_tens_an", an_a, 4'b1101);
        cycles(DIV);
        check("inv_hund_an", an_a, 4'hF);

        // Enable dropped at idx=2, cnt=1 for 5 cycles.
        do_load(4'd1, 4'd2, 4'd3, 4'd4);
        wait_frame();
        wait_pos(2 * DIV + 1);
        enable = 1'b0;
        cycles(1);
        check("dis_an", an_a, 4'hF);
        check("dis_seg", seg_a, 7'h7F);
        cycles(4);
        enable = 1'b1;
        cycles(1);
        check("reen_an", an_a, 4'b1011);
        check("reen_seg", seg_a, 7'b0100100);
        cycles(2 * FRAME);

        // Reset mid-frame with a pending load: the load is discarded.
        wait_frame();
        cycles(1);
        do_load(4'd8, 4'd8, 4'd8, 4'd8);
        cycles(2);
        resetn = 1'b0;
        cycles(1);
        resetn = 1'b1;
        cycles(1);
        check("mid_rst_an", an_a, 4'b1110);
        check("mid_rst_seg", seg_a, 7'b1000000);
        cycles(2 * FRAME + 2);
        check("mid_rst_late_seg", seg_a, 7'b1000000);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            thousands = rand_digit(); hundreds = rand_digit();
            tens = rand_digit(); ones = rand_digit();
            load   = ($urandom_range(0, 5) == 0) ||
                     (m_pos == FRAME - 1 && $urandom_range(0, 2) == 0);
            enable = ($urandom_range(0, 9) != 0);
            resetn = ($urandom_range(0, 199) != 0);
            @(negedge clock);
        end
        load = 1'b0; enable = 1'b1; resetn = 1'b1;
        cycles(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the four BCD digits produced by the binary-to-BCD stage and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Digits are captured on a load strobe and applied only at a scan-frame boundary, so a display frame never mixes old and new digits.
- Applies leading-zero blanking and shows a dash for any non-BCD code.

Parameters:
- DIV, 50000, clock cycles each digit is lit (legal range ≥ 2).
- BLANK_LZ, 1, 1 = leading-zero blanking on; 0 = all four digits always shown.

Ports:
- clock  in  1  system clock, all state on rising edge.
- resetn  in  1  synchronous active-low reset.
- thousands  in  4  BCD digit 3.
- hundreds  in  4  BCD digit 2.
- tens  in  4  BCD digit 1.
- ones  in  4  BCD digit 0.
- load  in  1  1-cycle strobe that captures the four digits.
- enable  in  1  scan enable; 0 blanks the display and freezes the scan.
- seg  out  7  {g,f,e,d,c,b,a}, active low.
- an  out  4  digit anodes, active low; an[0] = ones, an[3] = thousands.
- frame_done  out  1  1-cycle pulse when a new frame starts.

Behaviour:
- Reset (resetn=0 at an edge):
  - cnt=0, idx=0, disp=0, pend=0, pend_valid=0.
  - seg=7'h7F, an=4'hF, frame_done=0.
- Prescaler:
  - When enable=1, cnt counts 0..DIV-1.
  - tick is true when cnt==DIV-1 and enable=1. On tick: cnt←0 and idx←idx+1 mod 4.
  - When enable=0, cnt and idx hold.
- Boundary: a tick with idx==3. On that edge:
  - idx←0.
  - disp←pend if pend_valid; then pend_valid←0.
  - frame_done←1 for exactly one cycle.
- Load rules:
  - load=1 on a non-boundary cycle: pend←inputs, pend_valid←1. A later load before the boundary overwrites pend (last wins).
  - load=1 on the boundary cycle: disp←inputs directly, pend_valid←0.
  - load is ignored while resetn=0.
- Output registers: seg and an are registered from the current idx, disp and enable, so outputs lag idx by 1 cycle.
- Digit selected by idx:
  - If enable=0 or the digit is blanked: an=4'hF, seg=7'h7F.
  - Otherwise: an has a single 0 at bit idx, and seg is the decode of disp[idx].
- Blanking (BLANK_LZ=1):
  - Thousands is blanked if it is 0.
  - Hundreds is blanked if thousands and hundreds are both 0.
  - Tens is blanked if thousands, hundreds and tens are all 0.
  - Ones is never blanked.
  - A non-BCD digit counts as nonzero.
- Decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = dash, 0111111
- Enable re-assert: scanning resumes at the held idx and cnt. No frame is restarted and no frame_done is generated.
- Reset mid-frame: all state returns to reset values on that edge, and any pending load is discarded.

Test Plan:
- Reset, DIV=4: hold resetn=0 for 2 cycles with load=1 → seg=7F, an=F, frame_done=0. After release, the ones slot shows "0" (seg=1000000, an=1110) with the 1-cycle lag.
- Load 1,2,3,4 at cycle 3 with enable=1, DIV=4:
  - disp is unchanged until the first frame_done (cycle 16 after release).
  - Then each slot is held 4 cycles in order: an=1110 seg=0011001, an=1101 seg=0110000, an=1011 seg=0100100, an=0111 seg=1111001.
  - frame_done pulses every 16 cycles.
- Blanking: load 0,0,0,7 → only the an=1110 slot is active (seg=1111000); other slots show an=F, seg=7F. Load 0,0,0,0 → a single "0". With BLANK_LZ=0, load 0,0,0,7 → all four slots lit.
- Load ordering:
  - Loads of 1,1,1,1 then 5,5,5,5 in the same frame → the next frame shows 5555.
  - A load of 9,9,9,9 on the boundary cycle → 9999 appears in the frame that starts on that edge.
- Invalid digit: load 0,0,A,3 → tens slot seg=0111111, thousands and hundreds slots blank, ones=0110000.
- Enable and mid-frame reset:
  - Drop enable at cnt=1, idx=2 for 5 cycles → next cycle an=F; after re-enable, idx=2 continues from cnt=1.
  - Assert resetn=0 mid-frame with pend_valid=1 → pending value is never displayed.
